// File: rtl/mu_pkg.sv
// Shared definitions for the mu_alu issue path: opcodes, Q16.16 constants,
// and the dispatcher state encoding.
package mu_pkg;

  localparam logic [2:0] OP_ADD          = 3'd0;
  localparam logic [2:0] OP_SUB          = 3'd1;
  localparam logic [2:0] OP_MUL          = 3'd2;
  localparam logic [2:0] OP_DIV          = 3'd3;
  localparam logic [2:0] OP_LOG2         = 3'd4;
  localparam logic [2:0] OP_INFO_GAIN    = 3'd5;
  localparam logic [2:0] OP_CLAIM_FACTOR = 3'd6;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;
  localparam logic [31:0] Q16_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q16_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } disp_state_t;

endpackage

// File: rtl/mu_op_dispatcher_if.sv
// Command, mu_alu and response streams of the dispatcher in one bundle.
// master: the surrounding system (issuer, mu_alu, consumer). slave: dispatcher.
interface mu_op_dispatcher_if #(parameter int TAG_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             alu_valid;
  logic [2:0]       alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_ready;
  logic [31:0]      alu_result;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_overflow;
  logic             rsp_timeout;
  logic [TAG_W-1:0] rsp_tag;

  logic             mu_clear;
  logic [31:0]      mu_total;
  logic             mu_sat;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output alu_ready, alu_result, alu_overflow,
    output rsp_ready, mu_clear,
    input  cmd_ready, alu_valid, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_timeout, rsp_tag,
    input  mu_total, mu_sat, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  alu_ready, alu_result, alu_overflow,
    input  rsp_ready, mu_clear,
    output cmd_ready, alu_valid, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_overflow, rsp_timeout, rsp_tag,
    output mu_total, mu_sat, busy
  );
endinterface

// File: rtl/mu_cmd_fifo.sv
// Synchronous command FIFO. Head word is visible combinationally on rdata.
// Pushes are ignored when full, pops when empty.
module mu_cmd_fifo #(
  parameter int W     = 71,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage: data words need no reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mu_op_dispatcher.sv
// Issue stage for mu_alu: queues commands, runs one op at a time through the
// ALU's level valid/ready handshake with a timeout, returns tagged responses
// and keeps a saturating total of successful INFO_GAIN results.
module mu_op_dispatcher
  import mu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mu_op_dispatcher_if.slave   bus
);

  localparam int W  = 3 + 32 + 32 + TAG_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  disp_state_t state, nstate;

  logic [W-1:0]     fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]      fifo_count;
  logic [2:0]       h_op;
  logic [31:0]      h_a, h_b;
  logic [TAG_W-1:0] h_tag;

  logic             ready_en;
  logic             alu_valid_q;
  logic [2:0]       alu_op_q;
  logic [31:0]      alu_a_q, alu_b_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    tmo_cnt;
  logic             rsp_valid_q, rsp_ovf_q, rsp_tmo_q;
  logic [31:0]      rsp_result_q;
  logic [31:0]      mu_total_q;
  logic             mu_sat_q;
  logic             accept, mu_add;
  logic [32:0]      mu_sum;

  mu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid & bus.cmd_ready),
    .pop   (fifo_pop),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {h_op, h_a, h_b, h_tag} = fifo_rdata;

  // cmd_ready is held low through reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next state and FIFO pop.
  always_comb begin
    nstate   = state;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        nstate   = ST_ISSUE;
      end
      ST_ISSUE:   if (bus.alu_ready || tmo_cnt == TMO_LAST) nstate = ST_RELEASE;
      ST_RELEASE: if (!bus.alu_ready) nstate = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) nstate = ST_IDLE;
      default:    nstate = ST_IDLE;
    endcase
  end

  // Datapath: latch the head op, capture the ALU answer or a timeout,
  // then present the response until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      tag_q        <= '0;
      tmo_cnt      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          alu_valid_q <= 1'b1;
          alu_op_q    <= h_op;
          alu_a_q     <= h_a;
          alu_b_q     <= h_b;
          tag_q       <= h_tag;
          tmo_cnt     <= '0;
        end
        ST_ISSUE: begin
          if (bus.alu_ready) begin
            rsp_result_q <= bus.alu_result;
            rsp_ovf_q    <= bus.alu_overflow;
            rsp_tmo_q    <= 1'b0;
            alu_valid_q  <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b1;
            rsp_tmo_q    <= 1'b1;
            alu_valid_q  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RELEASE: if (!bus.alu_ready) rsp_valid_q <= 1'b1;
        ST_RESP:    if (bus.rsp_ready)  rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Only a clean, strictly positive INFO_GAIN result feeds the mu ledger.
  assign accept = (state == ST_RESP) && bus.rsp_ready;
  assign mu_add = accept && (alu_op_q == OP_INFO_GAIN) && !rsp_ovf_q &&
                  !rsp_tmo_q && !rsp_result_q[31] && (rsp_result_q != '0);
  assign mu_sum = {1'b0, mu_total_q} + {1'b0, rsp_result_q};

  // Running mu total; clear beats a simultaneous add, saturation is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu_total_q <= '0;
      mu_sat_q   <= 1'b0;
    end else if (bus.mu_clear) begin
      mu_total_q <= '0;
      mu_sat_q   <= 1'b0;
    end else if (mu_add) begin
      if (mu_sum[32]) begin
        mu_total_q <= 32'hFFFF_FFFF;
        mu_sat_q   <= 1'b1;
      end else begin
        mu_total_q <= mu_sum[31:0];
      end
    end
  end

  assign bus.cmd_ready    = ready_en & ~fifo_full;
  assign bus.alu_valid    = alu_valid_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_timeout  = rsp_tmo_q;
  assign bus.rsp_tag      = tag_q;
  assign bus.mu_total     = mu_total_q;
  assign bus.mu_sat       = mu_sat_q;
  assign bus.busy         = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mu_op_dispatcher.sv
// Scoreboard bench for mu_op_dispatcher with a behavioural mu_alu stand-in.
module tb_mu_op_dispatcher;
  import mu_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  logic done_q;

  mu_op_dispatcher_if #(.TAG_W(TAG_W)) bus();

  mu_op_dispatcher #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU arithmetic for the ops the bench exercises.
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic o;
    case (op)
      OP_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB, OP_INFO_GAIN: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      default: begin r = a ^ b; o = 1'b0; end
    endcase
    return {o, r};
  endfunction

  // mu_alu stand-in: answers one cycle after valid, drops ready as soon as
  // valid drops; 'stuck' models an ALU that never answers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= bus.alu_valid && !stuck;
  end
  logic [32:0] stub_out;
  assign stub_out         = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_ready    = bus.alu_valid & done_q;
  assign bus.alu_result   = bus.alu_ready ? stub_out[31:0] : 32'h0;
  assign bus.alu_overflow = bus.alu_ready & stub_out[32];

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      res;
    logic             ovf;
    logic             tmo;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  longint unsigned mdl_mu = 0;
  logic mdl_sat = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted response with the queue head and keeps
  // the mu ledger model up to date.
  initial begin
    exp_t e;
    logic acc;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (!rst_n) begin
        mdl_mu = 0;
        mdl_sat = 1'b0;
      end else begin
        chk("mu_total", {32'h0, bus.mu_total}, mdl_mu);
        chk("mu_sat", {63'h0, bus.mu_sat}, {63'h0, mdl_sat});
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: tag %0d with nothing expected at %0t", bus.rsp_tag, $time);
          end else begin
            e = exp_q.pop_front();
            acc = 1'b1;
            chk("rsp_tag", {60'h0, bus.rsp_tag}, {60'h0, e.tag});
            chk("rsp_result", {32'h0, bus.rsp_result}, {32'h0, e.res});
            chk("rsp_overflow", {63'h0, bus.rsp_overflow}, {63'h0, e.ovf});
            chk("rsp_timeout", {63'h0, bus.rsp_timeout}, {63'h0, e.tmo});
          end
        end
        if (bus.mu_clear) begin
          mdl_mu = 0;
          mdl_sat = 1'b0;
        end else if (acc && e.op == OP_INFO_GAIN && !e.ovf && !e.tmo && $signed(e.res) > 0) begin
          mdl_mu = mdl_mu + e.res;
          if (mdl_mu > 64'hFFFF_FFFF) begin
            mdl_mu = 64'hFFFF_FFFF;
            mdl_sat = 1'b1;
          end
        end
      end
    end
  end

  function automatic exp_t mk_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] tag, input logic tmo);
    exp_t e;
    logic [32:0] r;
    r = alu_ref(op, a, b);
    e.op = op;
    e.tag = tag;
    e.tmo = tmo;
    e.res = tmo ? 32'h0 : r[31:0];
    e.ovf = tmo ? 1'b1 : r[32];
    return e;
  endfunction

  // One command beat; returns 1 ns after the transfer edge.
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic tmo);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: cmd_ready stayed 0 for tag %0d", tag);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_tag = tag;
    @(posedge clk);
    exp_q.push_back(mk_exp(op, a, b, tag, tmo));
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    while (!bus.rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: rsp_valid never rose", name);
    end
  endtask

  task automatic accept_one(input logic clr);
    wait_rsp_valid("accept_wait");
    bus.rsp_ready = 1'b1;
    bus.mu_clear = clr;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.mu_clear = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && n < limit) begin @(posedge clk); #1; n++; end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_busy", {63'h0, bus.busy}, 0);
  endtask

  initial begin
    int lat, vhi;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_tag = '0;
    bus.rsp_ready = 1'b0;
    bus.mu_clear = 1'b0;

    // Reset state.
    #1;
    chk("rst_cmd_ready", {63'h0, bus.cmd_ready}, 0);
    chk("rst_alu_valid", {63'h0, bus.alu_valid}, 0);
    chk("rst_rsp_valid", {63'h0, bus.rsp_valid}, 0);
    chk("rst_busy", {63'h0, bus.busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("cmd_ready_before_edge", {63'h0, bus.cmd_ready}, 0);
    @(posedge clk); #1;
    chk("cmd_ready_after_edge", {63'h0, bus.cmd_ready}, 1);

    // 1: ADD, latency from push to rsp_valid.
    bus.rsp_ready = 1'b1;
    push(OP_ADD, 32'h0001_0000, 32'h0002_0000, 4'd3, 1'b0);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("t1_latency", lat, 4);
    chk("t1_result", {32'h0, bus.rsp_result}, 64'h0003_0000);
    drain(50);

    // 2: INFO_GAIN accumulation, then clear wins over a simultaneous add.
    bus.rsp_ready = 1'b0;
    push(OP_INFO_GAIN, 32'h0005_0000, 32'h0002_0000, 4'd1, 1'b0);
    accept_one(1'b0);
    push(OP_INFO_GAIN, 32'h0005_0000, 32'h0002_0000, 4'd2, 1'b0);
    accept_one(1'b0);
    chk("t2_mu_sum", {32'h0, bus.mu_total}, 64'h0006_0000);
    push(OP_INFO_GAIN, 32'h0005_0000, 32'h0002_0000, 4'd3, 1'b0);
    accept_one(1'b1);
    chk("t2_mu_cleared", {32'h0, bus.mu_total}, 0);

    // 3: back-pressure, 4 queued + 1 in flight, then in-order release.
    bus.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) push(OP_ADD, $urandom, $urandom, TAG_W'(t), 1'b0);
    chk("t3_full_cmd_ready", {63'h0, bus.cmd_ready}, 0);
    chk("t3_busy", {63'h0, bus.busy}, 1);
    drain(200);

    // 4: ALU never answers -> timeout after 16 cycles in ISSUE.
    stuck = 1'b1;
    bus.rsp_ready = 1'b1;
    push(OP_ADD, 32'h1, 32'h2, 4'd7, 1'b1);
    vhi = 0;
    lat = 0;
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
      if (bus.alu_valid) vhi++;
    end
    chk("t4_issue_cycles", vhi, 16);
    chk("t4_timeout", {63'h0, bus.rsp_timeout}, 1);
    chk("t4_overflow", {63'h0, bus.rsp_overflow}, 1);
    chk("t4_result", {32'h0, bus.rsp_result}, 0);
    @(posedge clk); #1;
    stuck = 1'b0;
    push(OP_SUB, 32'h0003_0000, 32'h0001_0000, 4'd8, 1'b0);
    drain(50);

    // 5: saturation of the mu total, and stickiness.
    push(OP_INFO_GAIN, 32'h7FFF_FFFF, 32'h1, 4'd9, 1'b0);
    push(OP_INFO_GAIN, 32'h7FFF_FFFF, 32'h1, 4'd10, 1'b0);
    drain(50);
    chk("t5_mu_pre", {32'h0, bus.mu_total}, 64'hFFFF_FFFC);
    chk("t5_sat_pre", {63'h0, bus.mu_sat}, 0);
    push(OP_INFO_GAIN, 32'h7FFF_FFFF, 32'h1, 4'd11, 1'b0);
    drain(50);
    chk("t5_mu_sat_val", {32'h0, bus.mu_total}, 64'hFFFF_FFFF);
    chk("t5_sat", {63'h0, bus.mu_sat}, 1);
    push(OP_INFO_GAIN, 32'h0001_0000, 32'h0, 4'd12, 1'b0);
    push(OP_ADD, 32'h5, 32'h6, 4'd13, 1'b0);
    drain(50);
    chk("t5_mu_sticky", {32'h0, bus.mu_total}, 64'hFFFF_FFFF);
    chk("t5_sat_sticky", {63'h0, bus.mu_sat}, 1);

    // 6: reset while an op sits in ISSUE.
    stuck = 1'b1;
    bus.rsp_ready = 1'b0;
    push(OP_ADD, 32'h0000_1234, 32'h0000_5678, 4'd5, 1'b0);
    push(OP_SUB, 32'h0000_0011, 32'h0000_0022, 4'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_alu_valid", {63'h0, bus.alu_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_alu_valid", {63'h0, bus.alu_valid}, 0);
    chk("t6_alu_a", {32'h0, bus.alu_a}, 0);
    chk("t6_alu_op", {61'h0, bus.alu_op}, 0);
    chk("t6_rsp_tag", {60'h0, bus.rsp_tag}, 0);
    chk("t6_rsp_result", {32'h0, bus.rsp_result}, 0);
    chk("t6_mu_total", {32'h0, bus.mu_total}, 0);
    chk("t6_mu_sat", {63'h0, bus.mu_sat}, 0);
    chk("t6_cmd_ready", {63'h0, bus.cmd_ready}, 0);
    chk("t6_busy", {63'h0, bus.busy}, 0);
    exp_q.delete();
    stuck = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t6_idle_busy", {63'h0, bus.busy}, 0);
      chk("t6_no_rsp", {63'h0, bus.rsp_valid}, 0);
    end

    // Random traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.mu_clear = ($urandom_range(0, 59) == 0);
      op = 3'($urandom_range(0, 6));
      a = $urandom;
      b = $urandom;
      if (op == OP_INFO_GAIN && $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 32'h0010_0000);
        b = $urandom_range(0, 32'h0008_0000);
      end
      if ($urandom_range(0, 1) == 1 && bus.cmd_ready) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_tag = TAG_W'(i);
        exp_q.push_back(mk_exp(op, a, b, TAG_W'(i), 1'b0));
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.mu_clear = 1'b0;
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
